// File: rtl/tmr_fi_campaign.sv
// rtl/tmr_fi_campaign.sv - fault-injection campaign controller for a TMR processing element
module tmr_fi_campaign #(
  parameter int WORD_SIZE   = 16,
  parameter int SETTLE      = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WORD_SIZE-1:0] pe_right_in,
  input  logic [WORD_SIZE-1:0] pe_bottom_in,
  output logic [5:0]           fault_inject_bus,
  output logic                 phase_start,
  output logic [2:0]           cfg_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [7:0]           mismatch_count,
  output logic [2:0]           first_fail_cfg
);

  localparam int P  = SETTLE + HOLD_CYCLES;
  localparam int CW = $clog2(P + 1);
  localparam int IW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt;
  logic [IW-1:0]            sample_idx;
  logic [2*WORD_SIZE-1:0]   sample_word;
  logic [2*WORD_SIZE-1:0]   golden [HOLD_CYCLES];
  logic                     take_start, do_abort;
  logic                     sample_cyc, phase_end, last_phase, is_mismatch;

  // Single-MAC stuck-at encoding: bit 2k enables MAC k, bit 2k+1 is the stuck value.
  function automatic logic [5:0] cfg_bus(input logic [2:0] k);
    case (k)
      3'd1:    cfg_bus = 6'h01;
      3'd2:    cfg_bus = 6'h03;
      3'd3:    cfg_bus = 6'h04;
      3'd4:    cfg_bus = 6'h0C;
      3'd5:    cfg_bus = 6'h10;
      3'd6:    cfg_bus = 6'h30;
      default: cfg_bus = 6'h00;
    endcase
  endfunction

  assign phase_end   = (cnt == CW'(P - 1));
  assign last_phase  = (cfg_idx == 3'd6);
  assign sample_cyc  = (state == S_RUN) && (cnt >= CW'(SETTLE));
  assign sample_idx  = IW'(cnt - CW'(SETTLE));
  assign sample_word = {pe_right_in, pe_bottom_in};
  // A sample aborted on its closing edge is discarded rather than counted.
  assign is_mismatch = sample_cyc && !do_abort && (cfg_idx != 3'd0) &&
                       (sample_word != golden[sample_idx]);
  assign fail        = (mismatch_count != 8'd0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; start beats abort in IDLE because abort is only looked at in RUN.
  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    do_abort   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          take_start = 1'b1;
          state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          do_abort  = 1'b1;
          state_nxt = S_IDLE;
        end else if (phase_end && last_phase) begin
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Golden record of the fault-free phase; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (sample_cyc && (cfg_idx == 3'd0)) golden[sample_idx] <= sample_word;
  end

  // Phase sequencing, injection bus and result accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt              <= '0;
      cfg_idx          <= 3'd0;
      fault_inject_bus <= 6'h00;
      phase_start      <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mismatch_count   <= 8'd0;
      first_fail_cfg   <= 3'd0;
    end else begin
      phase_start <= 1'b0;
      done        <= 1'b0;
      if (take_start) begin
        cnt              <= '0;
        cfg_idx          <= 3'd0;
        fault_inject_bus <= 6'h00;
        phase_start      <= 1'b1;
        busy             <= 1'b1;
        mismatch_count   <= 8'd0;
        first_fail_cfg   <= 3'd0;
      end else if (state == S_RUN) begin
        if (do_abort) begin
          cnt              <= '0;
          cfg_idx          <= 3'd0;
          fault_inject_bus <= 6'h00;
          busy             <= 1'b0;
        end else begin
          if (is_mismatch) begin
            if (mismatch_count != 8'hFF) mismatch_count <= mismatch_count + 8'd1;
            if (first_fail_cfg == 3'd0)  first_fail_cfg <= cfg_idx;
          end
          if (phase_end) begin
            cnt <= '0;
            if (last_phase) begin
              cfg_idx          <= 3'd0;
              fault_inject_bus <= 6'h00;
              busy             <= 1'b0;
              done             <= 1'b1;
            end else begin
              cfg_idx          <= cfg_idx + 3'd1;
              fault_inject_bus <= cfg_bus(cfg_idx + 3'd1);
              phase_start      <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tmr_fi_campaign.sv
// tb/tb_tmr_fi_campaign.sv - self-checking bench for tmr_fi_campaign
module tb_tmr_fi_campaign;

  localparam int W   = 16;
  localparam int ST  = 2;
  localparam int H8  = 8;
  localparam int H64 = 64;
  localparam int P8  = ST + H8;
  localparam int P64 = ST + H64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         a_start = 1'b0, a_abort = 1'b0;
  logic [W-1:0] a_right, a_bottom;
  logic [5:0]   a_bus;
  logic         a_ps, a_busy, a_done, a_fail;
  logic [2:0]   a_cfg, a_first;
  logic [7:0]   a_cnt;

  logic         b_start = 1'b0, b_abort = 1'b0;
  logic [W-1:0] b_right, b_bottom;
  logic [5:0]   b_bus;
  logic         b_ps, b_busy, b_done, b_fail;
  logic [2:0]   b_cfg, b_first;
  logic [7:0]   b_cnt;

  tmr_fi_campaign #(.WORD_SIZE(W), .SETTLE(ST), .HOLD_CYCLES(H8)) dut (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .pe_right_in(a_right), .pe_bottom_in(a_bottom),
    .fault_inject_bus(a_bus), .phase_start(a_ps), .cfg_idx(a_cfg),
    .busy(a_busy), .done(a_done), .fail(a_fail),
    .mismatch_count(a_cnt), .first_fail_cfg(a_first)
  );

  tmr_fi_campaign #(.WORD_SIZE(W), .SETTLE(ST), .HOLD_CYCLES(H64)) dut_sat (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .pe_right_in(b_right), .pe_bottom_in(b_bottom),
    .fault_inject_bus(b_bus), .phase_start(b_ps), .cfg_idx(b_cfg),
    .busy(b_busy), .done(b_done), .fail(b_fail),
    .mismatch_count(b_cnt), .first_fail_cfg(b_first)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // PE model: a replayed operand sequence, with a per-configuration leak table
  // saying where the voter lets a fault through (1: bottom stuck FFFF, 2: right bit 0 flipped).
  logic [W-1:0] stim_r [128];
  logic [W-1:0] stim_b [128];
  logic [1:0]   leak   [7][128];
  int a_pos = 0, b_pos = 0;
  int a_w, a_c, b_w, b_c;

  function automatic int bus2cfg(input logic [5:0] b);
    case (b)
      6'h01: return 1;
      6'h03: return 2;
      6'h04: return 3;
      6'h0C: return 4;
      6'h10: return 5;
      6'h30: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [5:0] exp_bus(input int k);
    case (k)
      1: return 6'h01;
      2: return 6'h03;
      3: return 6'h04;
      4: return 6'h0C;
      5: return 6'h10;
      6: return 6'h30;
      default: return 6'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    a_pos <= a_ps ? 1 : ((a_pos < 1000) ? a_pos + 1 : a_pos);
    b_pos <= b_ps ? 1 : ((b_pos < 1000) ? b_pos + 1 : b_pos);
  end

  always_comb begin
    a_w      = a_ps ? 0 : (a_pos & 127);
    a_c      = bus2cfg(a_bus);
    a_right  = stim_r[a_w];
    a_bottom = stim_b[a_w];
    if (leak[a_c][a_w] == 2'd1)      a_bottom = 16'hFFFF;
    else if (leak[a_c][a_w] == 2'd2) a_right  = stim_r[a_w] ^ 16'h0001;
  end

  always_comb begin
    b_w      = b_ps ? 0 : (b_pos & 127);
    b_c      = bus2cfg(b_bus);
    b_right  = stim_r[b_w];
    b_bottom = stim_b[b_w];
    if (leak[b_c][b_w] == 2'd1)      b_bottom = 16'hFFFF;
    else if (leak[b_c][b_w] == 2'd2) b_right  = stim_r[b_w] ^ 16'h0001;
  end

  // Reference: every leaking sample position of a faulty configuration is one mismatch.
  function automatic int model_cnt(input int hold);
    int n = 0;
    for (int c = 1; c <= 6; c++)
      for (int s = 0; s < hold; s++)
        if (leak[c][ST + s] != 2'd0) n++;
    return (n > 255) ? 255 : n;
  endfunction

  function automatic int model_first(input int hold);
    for (int c = 1; c <= 6; c++)
      for (int s = 0; s < hold; s++)
        if (leak[c][ST + s] != 2'd0) return c;
    return 0;
  endfunction

  task automatic setup(input int mode);
    for (int i = 0; i < 128; i++) begin
      stim_r[i] = 16'($urandom);
      stim_b[i] = 16'($urandom) & 16'h7FFF;
      for (int c = 0; c < 7; c++) leak[c][i] = 2'd0;
    end
    case (mode)
      1: for (int i = 0; i < 128; i++) leak[4][i] = 2'd1;
      2: for (int c = 1; c <= 6; c++)
           for (int i = 0; i < 128; i++) leak[c][i] = (i % 2 == 1) ? 2'd1 : 2'd2;
      3: begin
           leak[2][0]      = 2'd1;
           leak[5][1]      = 2'd1;
           leak[2][ST + 3] = 2'd2;
           leak[6][P8 - 1] = 2'd1;
         end
      4: for (int c = 1; c <= 6; c++)
           for (int i = 0; i < 128; i++)
             leak[c][i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      5: for (int c = 1; c <= 2; c++)
           for (int i = 0; i < 128; i++) leak[c][i] = 2'd1;
      default: ;
    endcase
  endtask

  // One campaign on the HOLD=8 instance with a per-cycle trajectory check.
  task automatic run_a(input int abort_at, input int restart_at, input bit chain,
                       input int e_cnt, input int e_first, input string tag);
    int dn;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    for (int t = 1; t <= 7 * P8; t++) begin
      chk($sformatf("%s traj t=%0d", tag, t), 32'({a_busy, a_done, a_ps, a_bus}),
          32'({1'b1, 1'b0, ((t - 1) % P8 == 0), exp_bus((t - 1) / P8)}));
      if (t == abort_at) begin
        a_abort = 1'b1;
        @(posedge clk); #1 a_abort = 1'b0;
        chk({tag, " abort bus/busy/done"}, 32'({a_bus, a_busy, a_done}), 32'd0);
        dn = 0;
        repeat (7 * P8) begin
          @(posedge clk); #1;
          if (a_done || a_busy) dn++;
        end
        chk({tag, " abort no done/busy"}, dn, 0);
        chk({tag, " abort count"}, a_cnt, e_cnt);
        chk({tag, " abort first"}, a_first, e_first);
        chk({tag, " abort fail"}, a_fail, e_cnt != 0);
        return;
      end
      if (t == restart_at) a_start = 1'b1;
      @(posedge clk); #1 a_start = 1'b0;
    end
    chk({tag, " done pulse"}, 32'({a_done, a_busy, a_bus}), 32'({1'b1, 1'b0, 6'h00}));
    chk({tag, " count"}, a_cnt, e_cnt);
    chk({tag, " first"}, a_first, e_first);
    chk({tag, " fail"}, a_fail, e_cnt != 0);
    if (chain) begin
      a_start = 1'b1;
      @(posedge clk); #1;
      chk({tag, " start in FINISH ignored"}, 32'({a_busy, a_done, a_cnt}), 32'({1'b0, 1'b0, 8'(e_cnt)}));
      @(posedge clk); #1 a_start = 1'b0;
      chk({tag, " restart clears"}, 32'({a_busy, a_ps, a_cnt, a_first, a_fail}), 32'({1'b1, 1'b1, 8'd0, 3'd0, 1'b0}));
      a_abort = 1'b1;
      @(posedge clk); #1 a_abort = 1'b0;
      chk({tag, " chained abort"}, a_busy, 0);
    end else begin
      @(posedge clk); #1;
      chk({tag, " done one cycle"}, a_done, 0);
    end
  endtask

  task automatic run_b(input int e_cnt, input int e_first, input string tag);
    int n = 0, nb = 0;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    while (!b_done && n < 1000) begin
      if (b_busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " done seen"}, b_done, 1);
    chk({tag, " busy cycles"}, nb, 7 * P64);
    chk({tag, " count"}, b_cnt, e_cnt);
    chk({tag, " first"}, b_first, e_first);
    chk({tag, " fail"}, b_fail, e_cnt != 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int mode;
    int e_cnt;
    int e_first;
    bit use_model;
    bit chain;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int bad;
    vecs[0] = '{mode: 0, e_cnt: 0,  e_first: 0, use_model: 1'b0, chain: 1'b0};
    vecs[1] = '{mode: 1, e_cnt: 8,  e_first: 4, use_model: 1'b0, chain: 1'b1};
    vecs[2] = '{mode: 2, e_cnt: 48, e_first: 1, use_model: 1'b0, chain: 1'b0};
    vecs[3] = '{mode: 3, e_cnt: 2,  e_first: 2, use_model: 1'b0, chain: 1'b0};
    vecs[4] = '{mode: 4, e_cnt: 0,  e_first: 0, use_model: 1'b1, chain: 1'b0};
    vecs[5] = '{mode: 4, e_cnt: 0,  e_first: 0, use_model: 1'b1, chain: 1'b0};
    vecs[6] = '{mode: 4, e_cnt: 0,  e_first: 0, use_model: 1'b1, chain: 1'b0};
    setup(0);

    // Reset held while clocking, then idle.
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs A", 32'({a_bus, a_ps, a_cfg, a_busy, a_done, a_fail, a_cnt, a_first}), 32'd0);
    chk("reset outputs B", 32'({b_bus, b_ps, b_cfg, b_busy, b_done, b_fail, b_cnt, b_first}), 32'd0);
    rst = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if ({a_bus, a_ps, a_cfg, a_busy, a_done, a_fail, a_cnt, a_first} != '0) bad++;
    end
    chk("idle outputs stay 0", bad, 0);

    // Abort alone in IDLE is ignored; start and abort together: start wins.
    a_abort = 1'b1;
    @(posedge clk); #1;
    chk("abort in idle", a_busy, 0);
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0; a_abort = 1'b0;
    chk("start wins over abort", 32'({a_busy, a_ps, a_bus}), 32'({1'b1, 1'b1, 6'h00}));
    a_abort = 1'b1;
    @(posedge clk); #1 a_abort = 1'b0;
    chk("abort while busy", 32'({a_busy, a_done}), 32'd0);

    // Table-driven campaigns.
    for (int i = 0; i < 7; i++) begin
      int ec, ef;
      setup(vecs[i].mode);
      ec = vecs[i].use_model ? model_cnt(H8)   : vecs[i].e_cnt;
      ef = vecs[i].use_model ? model_first(H8) : vecs[i].e_first;
      run_a(-1, -1, vecs[i].chain, ec, ef, $sformatf("vec%0d", i));
    end

    // Start pulsed mid-run must not restart the campaign.
    setup(1);
    run_a(-1, 35, 1'b0, 8, 4, "midstart");

    // Abort in phase 3, cycle 5; partial results from cfg 1 and 2 remain.
    setup(5);
    run_a(3 * P8 + 6, -1, 1'b0, 16, 1, "abort");

    // Asynchronous reset between edges during cfg 6.
    setup(1);
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (6 * P8 + 2) @(posedge clk);
    #1;
    chk("pre-reset cfg/count", 32'({a_cfg, a_cnt, a_bus}), 32'({3'd6, 8'd8, 6'h30}));
    #2 rst = 1'b0;
    #1;
    chk("async reset clears", 32'({a_bus, a_busy, a_cnt, a_first, a_fail, a_cfg}), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    setup(0);
    run_a(-1, -1, 1'b0, 0, 0, "post-reset");

    // Saturation and a randomized run on the HOLD=64 instance.
    setup(2);
    run_b(255, 1, "sat");
    setup(4);
    run_b(model_cnt(H64), model_first(H64), "bRand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmr_fi_campaign.md
# tmr_fi_campaign

Fault-injection campaign controller for one TMR processing element: the driving end of the PE's 6-bit `fault_inject_bus`. It steps through a golden (fault-free) phase and then every single-MAC stuck-at configuration, and records the PE's voted `right_out`/`bottom_out` during the golden phase. It compares each faulty phase against that golden record and reports whether the voter masked every single-MAC fault. It sits beside a TMR PE in the BIST path; a stimulus source replays the same operand sequence each phase, aligned on `phase_start`.

## Interface
- `WORD_SIZE`, 16, width of the observed PE outputs
- `SETTLE`, 2, cycles at the start of each phase that are ignored (MAC pipeline fill); ≥1
- `HOLD_CYCLES`, 8, sampled cycles per phase; 1..255
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin campaign; sampled only in IDLE
- `abort`  in  1  terminate campaign; sampled only while busy
- `pe_right_in`  in  WORD_SIZE  voted `right_out` of the PE under test
- `pe_bottom_in`  in  WORD_SIZE  voted `bottom_out` of the PE under test
- `fault_inject_bus`  out  6  registered; bits [2k+1:2k] drive MAC k; bit 0 = enable, bit 1 = stuck value
- `phase_start`  out  1  one-cycle pulse in the first cycle of each phase
- `cfg_idx`  out  3  current configuration, 0..6
- `busy`  out  1  campaign in progress
- `done`  out  1  one-cycle pulse on normal completion
- `fail`  out  1  `mismatch_count` != 0
- `mismatch_count`  out  8  saturating count of mismatching sample cycles
- `first_fail_cfg`  out  3  first configuration that mismatched; 0 = none

## Operation
- States: IDLE, RUN, FINISH.
- IDLE -> RUN when `start`=1.
- RUN -> FINISH after the last cycle of configuration 6.
- RUN -> IDLE when `abort`=1.
- FINISH -> IDLE unconditionally.
- Configuration table for `cfg_idx` (value on `fault_inject_bus`):
  - 0 = 6'h00 (golden)
  - 1 = 6'h01 (MAC0 stuck-at-0); 2 = 6'h03 (MAC0 stuck-at-1)
  - 3 = 6'h04 (MAC1 stuck-at-0); 4 = 6'h0C (MAC1 stuck-at-1)
  - 5 = 6'h10 (MAC2 stuck-at-0); 6 = 6'h30 (MAC2 stuck-at-1)
- Phase length is P = SETTLE + HOLD_CYCLES cycles. A phase counter c runs 0..P-1. Cycles with c ≥ SETTLE are sample cycles, with sample index s = c − SETTLE.
- Golden phase (cfg 0): store {`pe_right_in`, `pe_bottom_in`} into a golden buffer of HOLD_CYCLES × 2·WORD_SIZE at index s.
- Faulty phases (cfg 1..6): a sample cycle mismatches if either word differs from golden[s]. Each mismatch increments `mismatch_count`, which saturates at 255. On the first mismatch of the campaign, `first_fail_cfg` latches `cfg_idx` and keeps that value.
- Accepting `start` clears `mismatch_count`, `first_fail_cfg` and `fail` on the same edge that sets `busy`.
- Results hold after `done` or `abort` until the next accepted `start`.
- `start` while busy is ignored. `abort` in IDLE or FINISH is ignored.
- `abort` and `start` high in the same IDLE cycle: `start` wins.
- On `abort`: on the next edge `fault_inject_bus`=0, `busy`=0 and state = IDLE. No `done` pulse. Results keep their partial values.
- Golden buffer contents are never reset and need no reset.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset acts asynchronously, so `fault_inject_bus` goes to 0 without a clock edge, including mid-campaign.
- `start` high at edge N: from N+1, `busy`=1, `cfg_idx`=0, `phase_start`=1, bus=6'h00.
- Phase k occupies cycles N+1+k·P through N+(k+1)·P. `cfg_idx`, `fault_inject_bus` and `phase_start` all change on the same edge at each phase boundary.
- Sample data is taken combinationally from `pe_*_in` in the sample cycle and registered at its closing edge. A mismatch on a sample cycle appears in `mismatch_count` one cycle later.
- `busy` is high for 7·P cycles. In cycle N+1+7·P, `done`=1 and `busy`=0; this is the FINISH state. `fail` and the count are final in that cycle.
- A new `start` is accepted in the cycle after the `done` pulse at the earliest.

## Test plan
- Reset: hold `rst`=0 while clocking -> every output 0. Release `rst`, keep `start`=0 for 20 cycles -> outputs stay 0.
- Clean campaign, SETTLE=2, HOLD=8, PE model with fault-masking voter and a fixed 10-word stimulus restarted on `phase_start`; `start` at edge 0:
  - bus steps 00,01,03,04,0C,10,30 every 10 cycles; `busy` high for 70 cycles.
  - `done` pulses at cycle 71; `fail`=0, `mismatch_count`=0, `first_fail_cfg`=0.
- Single leak: model forces `pe_bottom_in`=16'hFFFF whenever bus=6'h0C -> `mismatch_count`=8, `first_fail_cfg`=4, `fail`=1.
- Saturation, HOLD=64: every faulty sample mismatches (384) -> `mismatch_count` stops at 255, `first_fail_cfg`=1.
- Abort: `abort` in phase 3 cycle 5 -> next cycle bus=0, `busy`=0, no `done` pulse. `start` pulsed mid-run -> no restart and results unchanged.
- Async reset mid-run: drop `rst` between clock edges during cfg 6 -> bus, `busy` and results 0 immediately. After release, a new campaign runs cleanly.
